lif_layer_scheduler: RTL
========================

LIF_LAYER_SCHEDULER -- requirements
Module: lif_layer_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 4: number of LIF neurons sharing one weight-memory read port.
REQ-002 Parameter M, default 8: input spikes per neuron.
REQ-003 Parameter Nbits, default 2: weight precision.
REQ-004 Parameter AW, default $clog2(N_NEURONS) with a minimum of 1: weight-memory address width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 start  input  1  request to evaluate one timestep.
REQ-008 input_spikes  input  M  layer input spikes for the timestep.
REQ-009 wmem_rdata  input  M*Nbits  weight word, valid exactly 1 cycle after wmem_rd.
REQ-010 neuron_spike  input  N_NEURONS  registered spike_out of each neuron.
REQ-011 wmem_rd  output  1  weight-memory read strobe.
REQ-012 wmem_addr  output  AW  weight row index (equal to the neuron index).
REQ-013 weights_bus  output  M*Nbits  latched weights, broadcast to all neurons.
REQ-014 spikes_bus  output  M  latched input spikes, broadcast to all neurons.
REQ-015 neuron_enable  output  N_NEURONS  one-hot-or-zero enable to the neurons.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at timestep completion.
REQ-018 spike_vec  output  N_NEURONS  spikes of the last completed timestep.
REQ-019 timestep  output  16  count of completed timesteps.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, WAIT, RUN, CAPTURE, DONE.
REQ-021 IDLE: start=1 SHALL latch input_spikes into spikes_bus, set idx=0, and go to FETCH; start in any other state SHALL be ignored.
REQ-022 FETCH (1 cycle): wmem_rd=1 and wmem_addr=idx; then go to WAIT.
REQ-023 WAIT (1 cycle): latch wmem_rdata into weights_bus at the end of the cycle; then go to RUN.
REQ-024 RUN (exactly 2 cycles, counted by run_cnt): neuron_enable[idx]=1, all other bits 0; then go to CAPTURE.
REQ-025 CAPTURE (1 cycle): sample neuron_spike[idx] into shadow bit idx; if idx==N_NEURONS-1 go to DONE, else increment idx and go to FETCH.
REQ-026 DONE (1 cycle): done=1; copy the shadow into spike_vec; timestep increments, wrapping 0xFFFF to 0x0000; then go to IDLE.
REQ-027 Latency: with start sampled in cycle 0, done SHALL be high in cycle 5*N_NEURONS+1 (cycle 21 for N=4); busy SHALL be high in cycles 1..5*N_NEURONS+1.
REQ-028 neuron_enable SHALL never have more than one bit set; wmem_rd SHALL be 0 outside FETCH.
REQ-029 spike_vec, weights_bus and spikes_bus SHALL hold their values between updates.
REQ-030 start held continuously high SHALL begin a new timestep in the IDLE cycle that follows DONE, giving back-to-back timesteps with 1 idle cycle between them.
REQ-031 For N_NEURONS=1, the FSM SHALL pass through CAPTURE directly to DONE.

Reset
REQ-032 While reset=0: state=IDLE, idx=0, run_cnt=0, and every output and the shadow register SHALL be 0, independent of clk.
REQ-033 Reset asserted mid-timestep SHALL abort the timestep with no done pulse and no change to timestep after release; the first cycle after release SHALL be IDLE.

Structure
REQ-034 Package snn_sched_pkg SHALL hold the state enum and the constant RUN_CYCLES=2.
REQ-035 The block SHALL be a single module with no sub-module; the neuron datapaths stay external.

Verification
REQ-036 N=4, reset, then start with input_spikes=8'hA5 and memory row k = k+1 -> wmem_addr sequence 0,1,2,3; weights_bus=1,2,3,4 during the matching RUN; done in cycle 21; timestep=1.
REQ-037 neuron_spike=4'b1010 driven in every CAPTURE -> spike_vec=4'b1010 from the cycle after DONE; neuron_enable one-hot for 2 cycles per neuron.
REQ-038 start pulsed in cycles 3 and 10 of a timestep -> both ignored; exactly one done pulse.
REQ-039 start held high for 3 timesteps -> done in cycles 21, 43 and 65; timestep=3.
REQ-040 reset=0 in cycle 7, released in cycle 9 -> all outputs 0; no done; a later start runs a full timestep.
REQ-041 Preload timestep=0xFFFF via 65535 runs (or force it), then run one timestep -> timestep=0x0000.

Source files
------------

// File: rtl/snn_sched_pkg.sv
`default_nettype none
// ============================================================================
// snn_sched_pkg : state encoding and timing constants for the LIF layer scheduler
// Revision      : 1.0
// ============================================================================
package snn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    RUN     = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int RUN_CYCLES = 2;

endpackage
`default_nettype wire

// File: rtl/lif_layer_scheduler.sv
`default_nettype none
// ============================================================================
// lif_layer_scheduler : time-multiplexes one weight-memory port across N LIF neurons
// Revision            : 1.0
// ============================================================================
module lif_layer_scheduler
  import snn_sched_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int M         = 8,
  parameter int Nbits     = 2,
  parameter int AW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [M-1:0]         input_spikes,
  input  logic [M*Nbits-1:0]   wmem_rdata,
  input  logic [N_NEURONS-1:0] neuron_spike,
  output logic                 wmem_rd,
  output logic [AW-1:0]        wmem_addr,
  output logic [M*Nbits-1:0]   weights_bus,
  output logic [M-1:0]         spikes_bus,
  output logic [N_NEURONS-1:0] neuron_enable,
  output logic                 busy,
  output logic                 done,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic [15:0]          timestep
);

  localparam logic [AW-1:0]        LAST_IDX = AW'(N_NEURONS - 1);
  localparam logic [1:0]           RUN_LAST = 2'(RUN_CYCLES - 1);
  localparam logic [N_NEURONS-1:0] ONE_HOT0 = N_NEURONS'(1);

  state_t               state;
  logic [AW-1:0]        idx;
  logic [1:0]           run_cnt;
  logic [N_NEURONS-1:0] shadow;

  // The neuron index doubles as the weight row address.
  assign wmem_addr = idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      run_cnt       <= '0;
      shadow        <= '0;
      wmem_rd       <= 1'b0;
      weights_bus   <= '0;
      spikes_bus    <= '0;
      neuron_enable <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      spike_vec     <= '0;
      timestep      <= '0;
    end else begin
      // Strobes default low; each state re-asserts what the next state needs.
      wmem_rd       <= 1'b0;
      done          <= 1'b0;
      neuron_enable <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            spikes_bus <= input_spikes;
            idx        <= '0;
            wmem_rd    <= 1'b1;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          weights_bus   <= wmem_rdata;
          run_cnt       <= '0;
          neuron_enable <= ONE_HOT0 << idx;
          state         <= RUN;
        end
        RUN: begin
          if (run_cnt == RUN_LAST) begin
            run_cnt <= '0;
            state   <= CAPTURE;
          end else begin
            run_cnt       <= run_cnt + 2'd1;
            neuron_enable <= ONE_HOT0 << idx;
          end
        end
        CAPTURE: begin
          shadow[idx] <= neuron_spike[idx];
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx     <= idx + 1'b1;
            wmem_rd <= 1'b1;
            state   <= FETCH;
          end
        end
        DONE: begin
          spike_vec <= shadow;
          timestep  <= timestep + 16'd1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
